// File: rtl/if_stage_pkg.sv
// if_stage shared types: fetch FSM states, queue entry layout,
// fixed constants (NOP filler, PC increment) and a word-align helper.
package if_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// if_stage bus bundle: instruction-ROM req/gnt/rvalid channel plus
// the valid/ready channel to decode. master = fetch side, slave = env.
interface if_stage_if;

  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_gnt_i;
  logic        rom_rvalid_i;
  logic [31:0] rom_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        id_ready_i;

  modport master (
    output rom_req_o,
    output rom_addr_o,
    input  rom_gnt_i,
    input  rom_rvalid_i,
    input  rom_rdata_i,
    output if_valid_o,
    output if_pc_o,
    output if_inst_o,
    input  id_ready_i
  );

  modport slave (
    input  rom_req_o,
    input  rom_addr_o,
    output rom_gnt_i,
    output rom_rvalid_i,
    output rom_rdata_i,
    input  if_valid_o,
    input  if_pc_o,
    input  if_inst_o,
    output id_ready_i
  );

endinterface

// File: rtl/if_fetch_fifo.sv
// Fetch queue: DEPTH x {pc, inst} synchronous FIFO, sync active-low
// reset. Ports: push_i/wdata_i, pop_i, clear_i (wins), head_o, count_o.
module if_fetch_fifo
  import if_stage_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  fetch_entry_t  wdata_i,
  input  logic          pop_i,
  input  logic          clear_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = cnt_q == CW'(DEPTH);
  assign do_pop  = pop_i & (cnt_q != '0);
  // a pop frees the slot in the same cycle
  assign do_push = push_i & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clear_i && do_push) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, one-outstanding ROM fetch FSM and fetch
// queue feeding decode. Plain ports: clk, rst_n (sync, active-low),
// ex flush/target, id jump/target, dhnf stall. Bus: if_stage_if.master.
// Optional IF_BYPASS_EN: response goes straight to decode when the
// queue is empty and decode takes it in the same cycle.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_ins_flush_i,
  input  logic [31:0] ex_target_pc_i,
  input  logic        id_jump_i,
  input  logic [31:0] id_jump_pc_i,
  input  logic        dhnf_stall_i,
  if_stage_if.master  bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q;
  fetch_state_e  state_d;
  logic [31:0]   pc_q;
  logic [31:0]   pc_d;
  logic [31:0]   rpc_q;
  logic [31:0]   rpc_d;
  logic          req;
  logic          redir;
  logic [31:0]   tgt;
  logic          resp_ok;
  logic          byp;
  logic          push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          space;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  wdata;

  assign redir = ex_ins_flush_i | id_jump_i;

  always_comb begin
    tgt = pc_q;
    priority case (1'b1)
      ex_ins_flush_i: tgt = align_word(ex_target_pc_i);
      id_jump_i:      tgt = align_word(id_jump_pc_i);
      default:        tgt = pc_q;
    endcase
  end

  // response belongs to a still-wanted request
  assign resp_ok = (state_q == S_WAIT) & bus.rom_rvalid_i & ~redir;

`ifdef IF_BYPASS_EN
  assign byp = resp_ok & fifo_empty & bus.id_ready_i & ~dhnf_stall_i;
`else
  assign byp = 1'b0;
`endif

  assign push       = resp_ok & ~byp;
  assign fifo_empty = count == '0;
  assign fifo_pop   = ~fifo_empty & bus.id_ready_i & ~dhnf_stall_i;
  assign space      = (count != CW'(FIFO_DEPTH)) | fifo_pop;
  assign wdata      = '{pc: rpc_q, inst: bus.rom_rdata_i};

  if_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (fifo_pop),
    .clear_i (redir),
    .head_o  (head),
    .count_o (count)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rpc_d   = rpc_q;
    req     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!redir && space) state_d = S_REQ;
      end
      S_REQ: begin
        req = 1'b1;
        if (redir) begin
          // granted request is in flight and must be drained
          state_d = bus.rom_gnt_i ? S_DROP : S_IDLE;
        end else if (bus.rom_gnt_i) begin
          state_d = S_WAIT;
          rpc_d   = pc_q;
          pc_d    = pc_q + PC_INC;
        end
      end
      S_WAIT: begin
        if (redir) begin
          state_d = bus.rom_rvalid_i ? S_IDLE : S_DROP;
        end else if (bus.rom_rvalid_i) begin
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (bus.rom_rvalid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (redir) pc_d = tgt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= align_word(RESET_PC);
      rpc_q   <= align_word(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rpc_q   <= rpc_d;
    end
  end

  assign bus.rom_req_o  = req;
  assign bus.rom_addr_o = pc_q;
  assign bus.if_valid_o = ~fifo_empty | byp;

  always_comb begin
    bus.if_pc_o   = 32'h0;
    bus.if_inst_o = NOP_INST;
    if (!fifo_empty) begin
      bus.if_pc_o   = head.pc;
      bus.if_inst_o = head.inst;
    end else if (byp) begin
      bus.if_pc_o   = rpc_q;
      bus.if_inst_o = bus.rom_rdata_i;
    end
  end

endmodule
